tick_pwm: RTL
=============

// Module: tick_pwm
// PURPOSE
//  PWM generator stepped by a divided clock produced in the clk_in domain by the
//  upstream frequency divider. Rising edges of clk_div become one-cycle ticks that
//  advance a period counter. Duty updates arrive via valid/ready and apply glitch-free
//  at period boundaries. Drives LEDs, buzzers and motor enables.
// PARAMETERS
//  W       8    counter/duty width (bits)
//  PERIOD  200  ticks per PWM period (edge-aligned); 2 <= PERIOD <= 2**W
//  DUTY_RST 0   active duty value after reset
// PORTS
//  clk_in      in   1  system clock
//  rst_n       in   1  reset, synchronous, active-low
//  clk_div     in   1  divided clock, registered in clk_in domain
//  en          in   1  run enable
//  duty_in     in   W  requested duty, in ticks high per period
//  duty_valid  in   1  duty_in valid
//  duty_ready  out  1  shadow register free; transfer on valid&&ready
//  pwm_out     out  1  PWM output, registered
//  period_end  out  1  one-cycle pulse on the tick that wraps the counter
// BEHAVIOUR
//  Reset: cnt=0, dir=UP, clk_div_q=1 (no spurious edge), duty_act=DUTY_RST,
//   pending=0, pwm_out=0, period_end=0, duty_ready=1.
//  tick = clk_div & ~clk_div_q, combinational. One tick per clk_div rising edge.
//  Counter advances only on tick while en=1. Edge-aligned mode counts 0..PERIOD-1,
//   then wraps to 0. period_end=1 (registered) in the cycle after the wrapping tick.
//  pwm_out <= en && (cnt < duty_act). This is 1 cycle latency from cnt.
//   duty_act=0 gives always low. duty_act>=PERIOD gives always high (no clamp needed).
//  Handshake: duty_ready = ~pending. On valid&&ready: shadow<=duty_in, pending<=1.
//   At the boundary (the wrapping tick) with pending=1: duty_act<=shadow, pending<=0.
//   duty_ready returns high the next cycle.
//   If accept and boundary fall in the same cycle, the new shadow waits for the
//   following boundary. duty_valid while ready=0 is ignored, and the source holds.
//  en=0: cnt<=0, dir<=UP, pwm_out<=0, and no period_end. A pending shadow applies on
//   the next cycle (no boundary wait). Transfers are still accepted while en=0.
//  en rising: counting resumes from 0 on the next tick.
//  Reset mid-period returns all state to reset values on that edge, and the shadow
//   is discarded.
//  Arithmetic: cnt is W bits. The compare is unsigned and W-bit.
//   The wrap compare uses the constant PERIOD-1.
// CONFIGURATION
//  TICK_PWM_CENTER_EN defined: center-aligned mode.
//   cnt counts UP 0..PERIOD-1, then DOWN PERIOD-2..0.
//   The period is 2*(PERIOD-1) ticks.
//   The wrap tick moves cnt 1->0 in DOWN. period_end and duty updates key off it.
//   The pwm compare is unchanged, so the output is symmetric about cnt=PERIOD-1.
//  Not defined: edge-aligned only. The dir register and down logic are not built.
// STRUCTURE
//  Package tick_pwm_pkg: typedef enum logic {DIR_UP, DIR_DOWN} dir_t.
//   Also holds localparam helpers (width check of PERIOD against W).
//  Sub-module edge_tick: rising-edge detector. It contains the clk_div_q register,
//   resets to 1, and outputs tick.
//  Top: counter/dir FSM, shadow+pending handshake, and output registers.
// TESTING (PERIOD=4, W=3, clk_div toggling every 2 clk_in -> tick every 4 cycles)
//  1 Reset held 3 cycles, clk_div=1 at release.
//    -> pwm_out=0, period_end=0, duty_ready=1, no tick until clk_div goes 0->1.
//  2 en=1, send duty 2 and let it apply.
//    -> pwm_out high for 2 ticks (8 cycles), low for 2 ticks, repeating.
//    -> period_end pulses every 16 cycles.
//  3 Duty 0 -> pwm_out constantly 0. Duty 4 and duty 7 -> pwm_out constantly 1
//    after 1 cycle.
//  4 Send duty 3 at cnt=1.
//    -> duty_ready drops next cycle. A second valid (duty 1) is ignored.
//    -> 3 applies at the wrap, and duty_ready rises the cycle after.
//  5 rst_n low for 1 cycle at cnt=2 with pending=1.
//    -> all outputs return to reset values and the shadow is lost.
//    -> with en=0, a new duty applies within 1 cycle.
//  6 TICK_PWM_CENTER_EN, duty 2.
//    -> cnt sequence 0,1,2,3,2,1.
//    -> pwm_out 1,1,0,0,0,1 per tick.
//    -> period_end every 6 ticks.

Source files
------------

// File: rtl/tick_pwm_pkg.sv
// ============================================================================
// Module : tick_pwm_pkg
// Brief  : Shared types and elaboration helpers for the tick-stepped PWM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package tick_pwm_pkg;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam int c_PERIOD_MIN = 2;

  // PERIOD-1 must be representable in the W-bit counter.
  function automatic bit period_fits(input int period, input int width);
    return (period >= c_PERIOD_MIN) && (period <= (1 << width));
  endfunction

endpackage

`default_nettype wire

// File: rtl/tick_pwm_if.sv
// ============================================================================
// Module : tick_pwm_if
// Brief  : Duty-update valid/ready channel into the PWM shadow register.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface tick_pwm_if #(
  parameter int W = 8
) ();
  logic [W-1:0] duty_in;
  logic         duty_valid;
  logic         duty_ready;

  modport master (output duty_in, output duty_valid, input  duty_ready);
  modport slave  (input  duty_in, input  duty_valid, output duty_ready);
endinterface

`default_nettype wire

// File: rtl/tick_pwm_edge_tick.sv
// ============================================================================
// Module : edge_tick
// Brief  : Rising-edge detector turning clk_div into one-cycle clk_in ticks.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module edge_tick (
  input  wire logic clk_in,
  input  wire logic rst_n,
  input  wire logic clk_div,
  output logic      tick
);

  logic r_clk_div_q;

  // Resetting high suppresses a false edge when clk_div is already high.
  always_ff @(posedge clk_in) begin
    if (!rst_n) r_clk_div_q <= 1'b1;
    else        r_clk_div_q <= clk_div;
  end

  assign tick = clk_div & ~r_clk_div_q;

endmodule

`default_nettype wire

// File: rtl/tick_pwm.sv
// ============================================================================
// Module : tick_pwm
// Brief  : Tick-stepped PWM with shadowed duty updates applied at period wrap.
//          Define TICK_PWM_CENTER_EN for center-aligned (up/down) counting.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tick_pwm
  import tick_pwm_pkg::*;
#(
  parameter int           W        = 8,
  parameter int           PERIOD   = 200,
  parameter logic [W-1:0] DUTY_RST = '0
) (
  input  wire logic       clk_in,
  input  wire logic       rst_n,
  input  wire logic       clk_div,
  input  wire logic       en,
  tick_pwm_if.slave       duty_if,
  output logic            pwm_out,
  output logic            period_end
);

  localparam logic [W-1:0] c_CNT_LAST = W'(PERIOD - 1);
  localparam logic [W-1:0] c_ONE      = W'(1);

  if (!period_fits(PERIOD, W)) begin : g_bad_period
    $error("tick_pwm: PERIOD out of range for W");
  end

  logic         w_tick;
  logic         w_wrap;
  logic [W-1:0] r_cnt;
  logic [W-1:0] w_cnt_nxt;
  logic [W-1:0] r_shadow;
  logic [W-1:0] r_duty_act;
  logic         r_pending;
  logic         w_accept;
  logic         w_apply;

  edge_tick u_edge_tick (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .clk_div (clk_div),
    .tick    (w_tick)
  );

`ifdef TICK_PWM_CENTER_EN
  dir_t r_dir;
  dir_t w_dir_nxt;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_dir <= DIR_UP;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_dir <= w_dir_nxt;
    end
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    w_dir_nxt = r_dir;
    w_wrap    = 1'b0;
    if (!en) begin
      w_cnt_nxt = '0;
      w_dir_nxt = DIR_UP;
    end else if (w_tick) begin
      case (r_dir)
        DIR_UP: begin
          if (r_cnt == c_CNT_LAST) begin
            // With PERIOD=2 the top step is also the 1->0 wrap.
            if (PERIOD == 2) begin
              w_cnt_nxt = '0;
              w_wrap    = 1'b1;
            end else begin
              w_cnt_nxt = c_CNT_LAST - c_ONE;
              w_dir_nxt = DIR_DOWN;
            end
          end else begin
            w_cnt_nxt = r_cnt + c_ONE;
          end
        end
        DIR_DOWN: begin
          w_cnt_nxt = r_cnt - c_ONE;
          if (r_cnt == c_ONE) begin
            w_wrap    = 1'b1;
            w_dir_nxt = DIR_UP;
          end
        end
        default: begin
          w_cnt_nxt = '0;
          w_dir_nxt = DIR_UP;
        end
      endcase
    end
  end
`else
  always_ff @(posedge clk_in) begin
    if (!rst_n) r_cnt <= '0;
    else        r_cnt <= w_cnt_nxt;
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    w_wrap    = 1'b0;
    if (!en) begin
      w_cnt_nxt = '0;
    end else if (w_tick) begin
      if (r_cnt == c_CNT_LAST) begin
        w_cnt_nxt = '0;
        w_wrap    = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + c_ONE;
      end
    end
  end
`endif

  // Accept needs pending=0 and apply needs pending=1, so a transfer landing on
  // a wrap cycle naturally waits for the following boundary.
  assign w_accept           = duty_if.duty_valid && !r_pending;
  assign w_apply            = r_pending && (w_wrap || !en);
  assign duty_if.duty_ready = ~r_pending;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_shadow   <= '0;
      r_pending  <= 1'b0;
      r_duty_act <= DUTY_RST;
      pwm_out    <= 1'b0;
      period_end <= 1'b0;
    end else begin
      if (w_accept) begin
        r_shadow  <= duty_if.duty_in;
        r_pending <= 1'b1;
      end else if (w_apply) begin
        r_duty_act <= r_shadow;
        r_pending  <= 1'b0;
      end
      pwm_out    <= en && (r_cnt < r_duty_act);
      period_end <= w_wrap;
    end
  end

endmodule

`default_nettype wire
